// File: rtl/player_motion.sv
// Player motion controller: per-frame jump/gravity FSM with collision-driven DEAD state.
// Optional mid-air double jump is enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion #(
  parameter logic [7:0] PLAYER_X    = 8'd20,
  parameter logic [6:0] GROUND_Y    = 7'd100,
  parameter logic [3:0] JUMP_V0     = 4'd6,
  parameter logic [3:0] V_MAX       = 4'd8,
  parameter logic [3:0] GRAVITY_DIV = 4'd1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       jump,
  input  logic       sig_collision,
  output logic [7:0] player_x,
  output logic [6:0] player_y,
  output logic [1:0] state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ST_GROUND  = 2'b00,
    ST_RISING  = 2'b01,
    ST_FALLING = 2'b10,
    ST_DEAD    = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] y_q, y_d;
  logic [3:0] v_q, v_d;
  logic [3:0] grav_cnt_q, grav_cnt_d;
  logic       jump_prev_q, jump_prev_d;
  logic       pending_q, pending_d;
  logic       hit_q, hit_d;
  logic       game_over_q, game_over_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic       dj_used_q, dj_used_d;
`endif

  logic       jump_edge;
  logic       pending_now;
  logic       hit_now;
  logic       grav_step;
  logic       restart;
  logic [3:0] v_inc;
  logic [3:0] v_fall;
  logic [7:0] y_fall_sum;

  always_comb begin
    jump_edge   = jump & ~jump_prev_q;
    // Same-cycle terms let an edge or collision on the tick cycle itself count.
    pending_now = pending_q | jump_edge;
    hit_now     = hit_q | sig_collision;
    grav_step   = (grav_cnt_q == (GRAVITY_DIV - 4'd1));
    v_inc       = (v_q >= V_MAX) ? V_MAX : (v_q + 4'd1);
    v_fall      = grav_step ? v_inc : v_q;
    y_fall_sum  = {1'b0, y_q} + {4'b0000, v_fall};

    state_d     = state_q;
    y_d         = y_q;
    v_d         = v_q;
    grav_cnt_d  = grav_cnt_q;
    jump_prev_d = jump;
    pending_d   = pending_now;
    hit_d       = (state_q != ST_DEAD) ? hit_now : 1'b0;
    restart     = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    dj_used_d   = dj_used_q;
`endif

    if (frame_tick) begin
      pending_d = 1'b0;
      hit_d     = 1'b0;
      if ((state_q != ST_DEAD) && hit_now) begin
        state_d = ST_DEAD;
      end else if (state_q == ST_DEAD) begin
        if (pending_now) begin
          state_d = ST_GROUND;
          y_d     = GROUND_Y;
          v_d     = 4'd0;
        end
      end else if (state_q == ST_GROUND) begin
        if (pending_now) begin
          state_d = ST_RISING;
          v_d     = JUMP_V0;
        end
`ifdef PLAYER_DOUBLE_JUMP_EN
      end else if (pending_now && !dj_used_q) begin
        state_d   = ST_RISING;
        v_d       = JUMP_V0;
        dj_used_d = 1'b1;
        restart   = 1'b1;
`endif
      end else if (state_q == ST_RISING) begin
        if (y_q < {3'b000, v_q}) begin
          y_d     = 7'd0;
          v_d     = 4'd0;
          state_d = ST_FALLING;
        end else begin
          y_d = y_q - {3'b000, v_q};
          if (grav_step) begin
            v_d = v_q - 4'd1;
            if (v_q == 4'd1) state_d = ST_FALLING;
          end
        end
      end else begin
        // Landing test is done at 8 bits so a large step cannot wrap past the ground.
        if (y_fall_sum >= {1'b0, GROUND_Y}) begin
          state_d = ST_GROUND;
          y_d     = GROUND_Y;
          v_d     = 4'd0;
`ifdef PLAYER_DOUBLE_JUMP_EN
          dj_used_d = 1'b0;
`endif
        end else begin
          y_d = y_fall_sum[6:0];
          v_d = v_fall;
        end
      end

      if ((state_d != state_q) || restart) begin
        grav_cnt_d = 4'd0;
      end else if ((state_q == ST_RISING) || (state_q == ST_FALLING)) begin
        grav_cnt_d = grav_step ? 4'd0 : (grav_cnt_q + 4'd1);
      end
    end

    game_over_d = (state_d == ST_DEAD);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_GROUND;
      y_q         <= GROUND_Y;
      v_q         <= 4'd0;
      grav_cnt_q  <= 4'd0;
      jump_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      hit_q       <= 1'b0;
      game_over_q <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_used_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      v_q         <= v_d;
      grav_cnt_q  <= grav_cnt_d;
      jump_prev_q <= jump_prev_d;
      pending_q   <= pending_d;
      hit_q       <= hit_d;
      game_over_q <= game_over_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      dj_used_q   <= dj_used_d;
`endif
    end
  end

  assign player_x  = PLAYER_X;
  assign player_y  = y_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: doc/player_motion.md
# player_motion

Player motion controller: supplies `player_x`/`player_y` to the pixel overlay stage and consumes its per-pixel `sig_collision` output. It runs a per-frame jump/gravity state machine clocked by a one-cycle frame tick. It latches any collision seen during a frame and enters a dead state at the next tick. It sits between the user input (jump key) and the overlay/renderer path.

## Interface
- `PLAYER_X`, 8'd20: fixed player column (top-left x).
- `GROUND_Y`, 7'd100: top-left y when standing; must be ≥ 0 and ≤ 119-9.
- `JUMP_V0`, 4'd6: initial upward speed, pixels/frame; must be ≥ 1.
- `V_MAX`, 4'd8: terminal falling speed, pixels/frame.
- `GRAVITY_DIV`, 4'd1: frame ticks per speed change; must be ≥ 1.

- `clock` in 1: system clock.
- `resetn` in 1: reset; one clock; reset is synchronous and active-low.
- `frame_tick` in 1: one-cycle pulse, once per frame.
- `jump` in 1: jump key, level, synchronous to `clock`.
- `sig_collision` in 1: overlay collision indication, sampled every cycle.
- `player_x` out 8: always `PLAYER_X`.
- `player_y` out 7: player top-left y, registered.
- `state` out 2: 00 GROUND, 01 RISING, 10 FALLING, 11 DEAD.
- `game_over` out 1: high iff `state` == DEAD.

## Operation
- Reset values: `state`=GROUND, `player_y`=`GROUND_Y`, speed v=0, gravity counter=0, jump pending=0, hit latch=0, `game_over`=0, double-jump-used=0.
- Jump detection: rising edge of `jump` (registered previous value) sets the pending flag. The flag is cleared at every `frame_tick`, whether or not it is consumed. An edge coinciding with a tick counts for that tick.
- Hit latch: set on any cycle with `sig_collision`=1. It is cleared at every tick and ignored in DEAD.
- All motion updates occur only on `frame_tick` cycles. On each tick, evaluate the conditions in priority order:
  1. Not DEAD, and (hit latch or `sig_collision`): go to DEAD. `player_y` and v hold.
  2. DEAD with pending: go to GROUND, `player_y`=`GROUND_Y`, v=0.
  3. GROUND with pending: go to RISING, v=`JUMP_V0`, `player_y` unchanged.
  4. RISING:
     - If `player_y` < v: `player_y`=0, v=0, go to FALLING.
     - Otherwise `player_y` -= v. On a gravity step, v -= 1; if the new v is 0, go to FALLING.
  5. FALLING:
     - On a gravity step, v_next = min(v+1, `V_MAX`); otherwise v_next = v.
     - If `player_y` + v_next ≥ `GROUND_Y` (computed at 8 bits): `player_y`=`GROUND_Y`, v=0, go to GROUND, clear double-jump-used.
     - Otherwise `player_y` += v_next, v = v_next.
- Gravity step: the gravity counter counts ticks spent in RISING/FALLING. A step occurs when the counter reaches `GRAVITY_DIV`-1, and the counter then wraps to 0. The counter is reset to 0 on any state change.
- Outside ticks, all state holds. A `jump` held high produces only one edge.

## Timing
- All outputs are registered. Changes appear the cycle after the `frame_tick` cycle.
- Hit latch and pending flag are updated the same cycle as their input. A collision on the tick cycle itself is also honoured, through the direct `sig_collision` term.
- Reset asserted mid-air or in DEAD restores all reset values on the next edge. A tick during reset is ignored.
- Simultaneous collision and jump on one tick: collision wins, and the jump is discarded.

## Configuration
- `PLAYER_DOUBLE_JUMP_EN` defined: in RISING or FALLING, a pending jump at a tick with double-jump-used=0 (and no collision) goes to RISING with v=`JUMP_V0` and sets double-jump-used.
- Not defined: mid-air jump requests are discarded at the tick, and the double-jump-used register is absent.

## Test plan
- Reset, then 3 ticks with no input -> `state`=00, `player_y`=100, `player_x`=20, `game_over`=0.
- Pulse `jump`, then 13 ticks (defaults) -> after tick 1: RISING, y=100; y sequence 94,89,85,82,80,79 (tick 7 → FALLING); then 80,82,85,89,94,100; tick 13 → GROUND.
- Single-cycle `sig_collision` mid-frame during RISING at y=85, then tick -> `state`=11, `game_over`=1, y holds 85; next tick without jump stays DEAD; jump + tick -> GROUND, y=100.
- `jump` edge and `sig_collision` on the same tick cycle while in GROUND -> DEAD, y=100.
- `GROUND_Y`=5, `JUMP_V0`=8, jump -> the second tick clamps y to 0 and goes FALLING with v=0, with no wrap to 7'h7x.
- With `PLAYER_DOUBLE_JUMP_EN`: jump at y=80 in FALLING -> RISING, v=6; a third jump is ignored until landing. Without the macro, the same stimulus leaves FALLING unchanged.
